// File: rtl/iter_multdiv.sv
// -----------------------------------------------------------------------------
// iter_multdiv
//
// Iterative signed multiply / divide unit feeding the execute-stage result
// register. One Booth (multiply) or restoring-division (divide) step is
// performed per clock. Every operation has the same latency of WIDTH+1 cycles
// from the accept edge to the edge that raises result_ready.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-low
//   operand_a    : multiplicand / dividend (two's complement)
//   operand_b    : multiplier / divisor (two's complement)
//   start_mult   : one-cycle multiply request (wins over start_div)
//   start_div    : one-cycle divide request
//   result       : registered product (low WIDTH bits) or quotient
//   result_ready : one-cycle pulse, result/exception valid
//   exception    : multiply overflow, divide overflow or divide by zero
//   busy         : an operation is in flight; starts are ignored
// -----------------------------------------------------------------------------
module iter_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             start_mult,
    input  logic             start_div,
    output logic [WIDTH-1:0] result,
    output logic             result_ready,
    output logic             exception,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    count_reg;
    logic             op_div_reg;

    // Booth accumulator: {A[WIDTH-1:0], Q[WIDTH-1:0], q_minus_1}
    logic [2*WIDTH:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;

    // Restoring divider: quot_reg starts as the dividend magnitude; its top
    // bit is shifted into the partial remainder while quotient bits enter
    // from the bottom.
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             neg_quot_reg;
    logic             div_zero_reg;
    logic             div_ovf_reg;

    logic [WIDTH-1:0] result_reg;
    logic             exception_reg;
    logic             ready_reg;

    // ---------------------------------------------------------------------
    // Combinational step logic
    // ---------------------------------------------------------------------
    logic             start_any;
    logic             last_step;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   booth_hi;
    logic [WIDTH:0]   booth_mcand;
    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] booth_next;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    logic [WIDTH-1:0] prod_lo;
    logic             mult_ovf;
    logic [WIDTH-1:0] div_quot;

    assign start_any = start_mult | start_div;
    assign last_step = (count_reg == LAST_CNT);

    // Magnitudes are unsigned WIDTH-bit values, so the most negative operand
    // maps to 2^(WIDTH-1) without loss.
    assign abs_a = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;

    // The add/subtract is done one bit wider than A so that a most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    assign booth_hi    = {acc_reg[2*WIDTH], acc_reg[2*WIDTH:WIDTH+1]};
    assign booth_mcand = {mcand_reg[WIDTH-1], mcand_reg};

    always_comb begin
        booth_sum = booth_hi;
        case (acc_reg[1:0])
            2'b01:   booth_sum = booth_hi + booth_mcand;
            2'b10:   booth_sum = booth_hi - booth_mcand;
            default: booth_sum = booth_hi;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q_-1}: q_-1 falls off the bottom.
    assign booth_next = {booth_sum, acc_reg[WIDTH:1]};

    assign rem_shift = {rem_reg[WIDTH-1:0], quot_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};

    // Final product sits in acc_reg[2*WIDTH:1]; it fits in WIDTH bits only if
    // the upper half is a pure sign extension of the lower half.
    assign prod_lo  = acc_reg[WIDTH:1];
    assign mult_ovf = (acc_reg[2*WIDTH:WIDTH+1] != {WIDTH{acc_reg[WIDTH]}});
    assign div_quot = neg_quot_reg ? (~quot_reg + 1'b1) : quot_reg;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_mult) begin
                    state_next = MULT;
                end else if (start_div) begin
                    state_next = DIV;
                end
            end
            MULT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg     <= '0;
            op_div_reg    <= 1'b0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
            neg_quot_reg  <= 1'b0;
            div_zero_reg  <= 1'b0;
            div_ovf_reg   <= 1'b0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_any) begin
                        count_reg    <= '0;
                        op_div_reg   <= ~start_mult;
                        mcand_reg    <= operand_a;
                        acc_reg      <= {{WIDTH{1'b0}}, operand_b, 1'b0};
                        rem_reg      <= '0;
                        quot_reg     <= abs_a;
                        divisor_reg  <= abs_b;
                        neg_quot_reg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        div_zero_reg <= (operand_b == '0);
                        div_ovf_reg  <= (operand_a == MOST_NEG) &&
                                        (operand_b == ALL_ONES);
                    end
                end
                MULT: begin
                    acc_reg   <= booth_next;
                    count_reg <= count_reg + 1'b1;
                end
                DIV: begin
                    if (!rem_diff[WIDTH]) begin
                        rem_reg  <= rem_diff;
                        quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg  <= rem_shift;
                        quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
                    end
                    count_reg <= count_reg + 1'b1;
                end
                DONE: begin
                    ready_reg <= 1'b1;
                    if (!op_div_reg) begin
                        result_reg    <= prod_lo;
                        exception_reg <= mult_ovf;
                    end else if (div_zero_reg) begin
                        result_reg    <= '0;
                        exception_reg <= 1'b1;
                    end else if (div_ovf_reg) begin
                        result_reg    <= MOST_NEG;
                        exception_reg <= 1'b1;
                    end else begin
                        result_reg    <= div_quot;
                        exception_reg <= 1'b0;
                    end
                end
                default: begin
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign result       = result_reg;
    assign exception    = exception_reg;
    assign result_ready = ready_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_iter_multdiv.sv
module tb_iter_multdiv;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] result;
    logic        result_ready;
    logic        exception;
    logic        busy;

    iter_multdiv #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .result       (result),
        .result_ready (result_ready),
        .exception    (exception),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          last_accept = -1000;
    logic [31:0] exp_result = '0;
    logic        exp_exc = 1'b0;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    endtask

    // Reference: plain signed arithmetic. Returns {exception, result}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit is_div);
        longint p;
        int     q;
        logic [31:0] lo;
        logic   ovf;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            lo  = p[31:0];
            ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            return {ovf, lo};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, 32'(q)};
    endfunction

    function automatic bit model_busy(input int c);
        return (c >= last_accept) && (c <= last_accept + LAT - 1);
    endfunction

    // Per-cycle comparison, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk_en) begin
                bit due;
                due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                if (due) begin
                    exp_result = exp_q[0].res;
                    exp_exc    = exp_q[0].exc;
                    void'(exp_q.pop_front());
                end
                chk("ready", {32'd0, result_ready}, {32'd0, due});
                chk("busy", {32'd0, busy}, {32'd0, model_busy(cyc)});
                chk("result", {1'b0, result}, {1'b0, exp_result});
                chk("exception", {32'd0, exception}, {32'd0, exp_exc});
            end
        end
    end

    // Drive one start request at the current falling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit m, input bit d);
        operand_a  = a;
        operand_b  = b;
        start_mult = m;
        start_div  = d;
        if ((m || d) && reset && !model_busy(cyc)) begin
            logic [32:0] r;
            r = model(a, b, !m);
            last_accept = cyc + 1;
            exp_q.push_back('{last_accept + LAT, r[31:0], r[32]});
            $display("op %s a=%h b=%h accepted at cycle %0d expect %h exc %0d",
                     m ? "mul" : "div", a, b, last_accept, r[31:0], r[32]);
        end else begin
            $display("op %s a=%h b=%h ignored at cycle %0d", m ? "mul" : "div", a, b, cyc + 1);
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        exp_result  = '0;
        exp_exc     = 1'b0;
        last_accept = -1000;
        $display("reset asserted before cycle %0d", cyc + 1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($signed($urandom_range(0, 40)) - 20);
            5:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Model pins against hand-computed values.
        chk("pin_mul_7_m6", model(32'd7, 32'hFFFF_FFFA, 1'b0), {1'b0, 32'hFFFF_FFD6});
        chk("pin_mul_ovf", model(32'h0001_0000, 32'h0001_0000, 1'b0), {1'b1, 32'h0});
        chk("pin_div_m100_7", model(32'hFFFF_FF9C, 32'd7, 1'b1), {1'b0, 32'hFFFF_FFF2});
        chk("pin_div_zero", model(32'd5, 32'd0, 1'b1), {1'b1, 32'h0});
        chk("pin_div_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {1'b1, 32'h8000_0000});
        chk("pin_mul_9_9", model(32'd9, 32'd9, 1'b0), {1'b0, 32'd81});

        // Reset state.
        wait_cycles(3);
        chk("rst_result", {1'b0, result}, 33'd0);
        chk("rst_ready", {32'd0, result_ready}, 33'd0);
        chk("rst_exc", {32'd0, exception}, 33'd0);
        chk("rst_busy", {32'd0, busy}, 33'd0);
        reset  = 1'b1;
        chk_en = 1'b1;
        wait_cycles(2);

        // Directed cases.
        issue(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0);          wait_cycles(34);
        issue(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);  wait_cycles(34);
        issue(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);          wait_cycles(34);
        issue(32'd5, 32'd0, 1'b0, 1'b1);                  wait_cycles(34);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);  wait_cycles(34);
        issue(32'd3, 32'd4, 1'b1, 1'b1);                  wait_cycles(34);

        // Start while busy is dropped; start in the ready cycle is accepted.
        issue(32'd2, 32'd3, 1'b1, 1'b0);
        wait_until(last_accept + 9);
        issue(32'd100, 32'd5, 1'b0, 1'b1);
        wait_until(last_accept + LAT);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        wait_cycles(36);

        // Reset in the middle of a multiply, then 9 x 9.
        issue(32'd5, 32'd5, 1'b1, 1'b0);
        wait_until(last_accept + 14);
        do_reset();
        wait_cycles(3);
        issue(32'd9, 32'd9, 1'b1, 1'b0);
        wait_cycles(36);

        // Randomized traffic with varied gaps, including busy-time starts.
        for (int i = 0; i < 60; i++) begin
            int k;
            bit m;
            bit d;
            k = $urandom_range(0, 2);
            m = (k != 1);
            d = (k != 0);
            issue(rnd_operand(), rnd_operand(), m, d);
            case ($urandom_range(0, 3))
                0:       wait_cycles($urandom_range(0, 40));
                1:       wait_until(last_accept + LAT);
                default: wait_until(last_accept + LAT + 1 + $urandom_range(0, 3));
            endcase
        end

        wait_cycles(40);
        chk("drain", 33'(exp_q.size()), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iter_multdiv.md
# iter_multdiv

Iterative signed 32-bit multiply/divide unit that sits directly upstream of the execute-stage result register. It accepts two operands and a one-cycle start pulse, runs one shift/add or shift/subtract step per clock, and presents a 32-bit result with a one-cycle ready pulse and an exception flag. The downstream register captures `result` using `result_ready` as its write enable.

## Interface
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `operand_a`  in  WIDTH  multiplicand or dividend, two's complement.
- `operand_b`  in  WIDTH  multiplier or divisor, two's complement.
- `start_mult`  in  1  one-cycle request to multiply.
- `start_div`  in  1  one-cycle request to divide.
- `result`  out  WIDTH  product (low WIDTH bits) or quotient; registered.
- `result_ready`  out  1  single-cycle pulse; `result` and `exception` are valid.
- `exception`  out  1  overflow or divide-by-zero flag for the current result.
- `busy`  out  1  high from the accept edge until the edge that raises `result_ready`.

## Operation
- State machine: IDLE, MULT, DIV, DONE.
- IDLE
  - `start_mult` → latch operands, clear the step counter, go to MULT.
  - `start_div` → latch operands, clear the step counter, go to DIV.
  - Both starts high → MULT wins; the divide request is dropped.
- MULT
  - Radix-2 Booth algorithm on a 2·WIDTH+1-bit accumulator, one step per cycle.
  - After WIDTH steps, go to DONE.
- DIV
  - Restoring division on operand magnitudes, one quotient bit per cycle.
  - After WIDTH steps, go to DONE.
  - Quotient is negated when operand signs differ. Remainder is discarded.
- DONE
  - Register `result` and `exception`, pulse `result_ready`, return to IDLE.
- Exception rules
  - Multiply: `exception`=1 when the full 2·WIDTH product does not sign-extend from bit WIDTH-1. `result` is the low WIDTH bits regardless.
  - Divide by zero: `exception`=1, `result`=0. Full latency still applies.
  - Divide of 0x80000000 by 0xFFFFFFFF: `exception`=1, `result`=0x80000000.
- Start pulses while `busy` are ignored; in-flight operands are unaffected.
- `result` and `exception` hold their last values until the next DONE.
- Reset low
  - Takes effect on the next edge, including mid-operation.
  - Sets state to IDLE, counter to 0, `result`=0, `result_ready`=0, `exception`=0, `busy`=0.
  - In-flight operation is discarded with no ready pulse.

## Timing
- Accept edge E0: operands sampled, `busy` rises after E0.
- Edges E1…E(WIDTH) perform the iteration steps.
- `result_ready`, the new `result` and `exception` are visible after edge E(WIDTH+1).
  - Latency is WIDTH+1 cycles (33 at default), fixed for every operation.
- `result_ready` is high for exactly one cycle. `busy` falls on the same edge that raises it.
- A new start may be asserted in the cycle `result_ready` is high. It is accepted on that edge: back-to-back throughput is one op per WIDTH+1 cycles.
- Operand inputs need only be valid in the accept cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then `start_mult` with a=7, b=-6 → after 33 cycles `result`=0xFFFFFFD6 (-42), `exception`=0, `result_ready` high one cycle.
- `start_mult` with a=0x00010000, b=0x00010000 → `result`=0x00000000, `exception`=1.
- `start_div` with a=-100, b=7 → `result`=0xFFFFFFF2 (-14), `exception`=0. Then a=5, b=0 → `result`=0, `exception`=1 after 33 cycles.
- `start_div` with a=0x80000000, b=-1 → `result`=0x80000000, `exception`=1. Then `start_mult` and `start_div` asserted together with a=3, b=4 → `result`=12.
- `start_mult` with a=2, b=3, then `start_div` pulsed at cycle 10 while busy → only one ready pulse, at cycle 33, `result`=6. A new start issued in the ready cycle is accepted; its result arrives 33 cycles later.
- Drive `reset` low at cycle 15 of a multiply → after that edge all outputs are 0 and `busy`=0, with no ready pulse. A subsequent 9×9 multiply returns 81.
